// File: rtl/sram_pkg.sv
// Shared SRAM defaults used by the SRAM protocol interface and its controllers.
package sram_pkg;

   localparam int SRAM_AW = 15;
   localparam int SRAM_DW = 32;

   // Index width that stays at least one bit so a single-entry buffer still elaborates.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sram_rw_if_t.sv
// Single-port SRAM strobe interface: one access per cycle, read data one cycle later.
interface sram_rw_if_t #(
   parameter int AW = sram_pkg::SRAM_AW,
   parameter int DW = sram_pkg::SRAM_DW
);

   logic          cs;
   logic          wen;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;

   modport mst (output cs, wen, addr, wdata, input rdata);
   modport slv (input cs, wen, addr, wdata, output rdata);

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count; head data reads as zero while empty.
module sync_fifo
   import sram_pkg::*;
#(
   parameter int DW    = SRAM_DW,
   parameter int DEPTH = 2,
   localparam int PW   = idx_width(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] cnt
);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         if (push && !pop)      cnt <= cnt + 1'b1;
         else if (pop && !push) cnt <= cnt - 1'b1;
      end
   end

   // Storage is not reset; the empty gate below keeps stale words invisible.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   assign full  = (cnt == CW'(DEPTH));
   assign empty = (cnt == '0);
   assign rdata = empty ? '0 : mem[rd_ptr];

   a_no_overflow  : assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
   a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/sram_mst_ctrl.sv
// Valid/ready front end for a single-port SRAM: issues strobes and buffers read data behind a credit limit.
module sram_mst_ctrl
   import sram_pkg::*;
#(
   parameter int AW    = SRAM_AW,
   parameter int DW    = SRAM_DW,
   parameter int DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_vld,
   output logic          req_rdy,
   input  logic          req_wen,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_vld,
   input  logic          rsp_rdy,
   output logic [DW-1:0] rsp_rdata,
   sram_rw_if_t.mst      sram_rw_mst
);

   localparam int CW = $clog2(DEPTH + 1);

   logic          rd_inflight;
   logic          acc;
   logic          pop;
   logic          full;
   logic          empty;
   logic          rd_credit;
   logic [CW-1:0] cnt;
   logic [CW:0]   occ;

   // A read may only issue if its data is guaranteed a FIFO slot, counting the one in flight.
   always_comb begin
      occ       = {1'b0, cnt} + {{CW{1'b0}}, rd_inflight} - {{CW{1'b0}}, pop};
      rd_credit = (occ < (CW + 1)'(DEPTH));
      req_rdy   = rst_n & (req_wen | rd_credit);
      acc       = req_vld & req_rdy;
      pop       = rsp_vld & rsp_rdy;
   end

   assign sram_rw_mst.cs    = acc;
   assign sram_rw_mst.wen   = req_wen;
   assign sram_rw_mst.addr  = req_addr;
   assign sram_rw_mst.wdata = req_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_inflight <= 1'b0;
      else        rd_inflight <= acc & ~req_wen;
   end

   sync_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rd_inflight),
      .pop   (pop),
      .wdata (sram_rw_mst.rdata),
      .rdata (rsp_rdata),
      .full  (full),
      .empty (empty),
      .cnt   (cnt)
   );

   assign rsp_vld = ~empty;

   a_credit_holds : assert property (@(posedge clk) disable iff (!rst_n) !(rd_inflight && full && !pop));

endmodule

// File: tb/tb_sram_mst_ctrl.sv
// Randomised and directed checks of sram_mst_ctrl against an outstanding-read queue and reference memory.
module tb_sram_mst_ctrl;

   localparam int AW    = 15;
   localparam int DW    = 32;
   localparam int DEPTH = 2;

   logic          clk;
   logic          rst_n;
   logic          req_vld;
   logic          req_rdy;
   logic          req_wen;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_vld;
   logic          rsp_rdy;
   logic [DW-1:0] rsp_rdata;

   int tests_run;
   int tests_failed;
   int cyc;
   bit check_en;

   sram_rw_if_t #(.AW(AW), .DW(DW)) sram_if ();

   sram_mst_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_vld     (req_vld),
      .req_rdy     (req_rdy),
      .req_wen     (req_wen),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_vld     (rsp_vld),
      .rsp_rdy     (rsp_rdy),
      .rsp_rdata   (rsp_rdata),
      .sram_rw_mst (sram_if)
   );

   // Behavioural single-port SRAM with one-cycle registered read.
   logic [DW-1:0] sram_mem [2**AW];
   always @(posedge clk) begin
      if (sram_if.cs && sram_if.wen)  sram_mem[sram_if.addr] <= sram_if.wdata;
      if (sram_if.cs && !sram_if.wen) sram_if.rdata <= sram_mem[sram_if.addr];
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic apply_stimulus(input logic vld, input logic wen, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic rdy);
      @(posedge clk);
      #1;
      req_vld   = vld;
      req_wen   = wen;
      req_addr  = addr;
      req_wdata = wdata;
      rsp_rdy   = rdy;
      #1;
   endtask

   // Reference model: memory contents plus the ordered list of reads still owed to the consumer.
   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } rd_t;

   rd_t           exp_q[$];
   logic [DW-1:0] ref_mem [2**AW];
   logic          exp_vld;
   logic          exp_rdy;
   logic [DW-1:0] exp_data;
   logic          exp_pop;
   logic          exp_acc;

   always @(negedge clk) begin
      if (check_en) begin
         if (!rst_n) begin
            check_output("reset_rsp_vld", {31'b0, rsp_vld}, '0);
            check_output("reset_rsp_rdata", rsp_rdata, '0);
            check_output("reset_req_rdy", {31'b0, req_rdy}, '0);
            check_output("reset_cs", {31'b0, sram_if.cs}, '0);
            exp_q.delete();
         end else begin
            exp_vld  = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
            exp_data = exp_vld ? exp_q[0].data : '0;
            exp_pop  = exp_vld && rsp_rdy;
            exp_rdy  = req_wen || ((exp_q.size() - int'(exp_pop)) < DEPTH);
            exp_acc  = req_vld && exp_rdy;
            check_output("req_rdy", {31'b0, req_rdy}, {31'b0, exp_rdy});
            check_output("cs", {31'b0, sram_if.cs}, {31'b0, exp_acc});
            check_output("rsp_vld", {31'b0, rsp_vld}, {31'b0, exp_vld});
            if (exp_vld) check_output("rsp_rdata", rsp_rdata, exp_data);
            if (exp_acc) begin
               check_output("sram_wen", {31'b0, sram_if.wen}, {31'b0, req_wen});
               check_output("sram_addr", {17'b0, sram_if.addr}, {17'b0, req_addr});
               if (req_wen) check_output("sram_wdata", sram_if.wdata, req_wdata);
            end
            if (exp_pop) void'(exp_q.pop_front());
            if (exp_acc) begin
               if (req_wen) ref_mem[req_addr] = req_wdata;
               else         exp_q.push_back('{data: ref_mem[req_addr], due: cyc + 2});
            end
         end
      end
   end

   task automatic drain();
      for (int i = 0; i < 30 && exp_q.size() != 0; i++) apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1);
      check_output("drain_empty", exp_q.size(), 0);
   endtask

   int accepted;

   initial begin
      tests_run = 0;
      tests_failed = 0;
      cyc = 0;
      check_en = 1'b0;
      rst_n = 1'b1;
      req_vld = 1'b1;
      req_wen = 1'b1;
      req_addr = '0;
      req_wdata = '0;
      rsp_rdy = 1'b0;
      sram_if.rdata = '0;
      for (int i = 0; i < 2**AW; i++) begin
         sram_mem[i] = DW'(i * 3);
         ref_mem[i]  = DW'(i * 3);
      end
      #1 rst_n = 1'b0;
      check_en = 1'b1;
      #1;
      check_output("rst_req_rdy_gated", {31'b0, req_rdy}, '0);
      check_output("rst_cs_gated", {31'b0, sram_if.cs}, '0);
      check_output("rst_rsp_vld", {31'b0, rsp_vld}, '0);
      check_output("rst_rsp_rdata", rsp_rdata, '0);
      apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1);
      apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1);
      rst_n = 1'b1;

      // Write then read-after-write of the same word.
      apply_stimulus(1'b1, 1'b1, 15'h10, 32'hDEADBEEF, 1'b1);
      check_output("wr_rdy", {31'b0, req_rdy}, 1);
      apply_stimulus(1'b1, 1'b0, 15'h10, '0, 1'b1);
      check_output("raw_rd_rdy", {31'b0, req_rdy}, 1);
      apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1);
      check_output("raw_no_early_rsp", {31'b0, rsp_vld}, 0);
      apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1);
      check_output("raw_rsp_vld", {31'b0, rsp_vld}, 1);
      check_output("raw_rsp_data", rsp_rdata, 32'hDEADBEEF);
      apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1);
      check_output("raw_single_rsp", {31'b0, rsp_vld}, 0);

      // Back-to-back reads at full throughput.
      for (int i = 0; i < 10; i++) begin
         if (i < 8) apply_stimulus(1'b1, 1'b0, AW'(i), '0, 1'b1);
         else       apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1);
         if (i < 8) check_output("b2b_rdy", {31'b0, req_rdy}, 1);
         if (i >= 2) begin
            check_output("b2b_vld", {31'b0, rsp_vld}, 1);
            check_output("b2b_data", rsp_rdata, DW'((i - 2) * 3));
         end
      end
      drain();

      // Back-pressure limits outstanding reads; writes still pass.
      accepted = 0;
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(1'b1, 1'b0, AW'(32 + accepted), '0, 1'b0);
         if (req_rdy) accepted++;
      end
      check_output("bp_accepted", accepted, 2);
      check_output("bp_rd_blocked", {31'b0, req_rdy}, 0);
      apply_stimulus(1'b1, 1'b1, 15'h30, 32'h1234_5678, 1'b0);
      check_output("bp_wr_rdy", {31'b0, req_rdy}, 1);
      check_output("bp_wr_cs", {31'b0, sram_if.cs}, 1);
      check_output("bp_wr_wen", {31'b0, sram_if.wen}, 1);
      apply_stimulus(1'b1, 1'b0, AW'(32 + accepted), '0, 1'b1);
      check_output("bp_head_data", rsp_rdata, 32'h60);
      for (int i = 0; i < 10 && accepted < 4; i++) begin
         if (req_rdy) accepted++;
         if (accepted < 4) apply_stimulus(1'b1, 1'b0, AW'(32 + accepted), '0, 1'b1);
      end
      check_output("bp_all_accepted", accepted, 4);
      drain();

      // Full FIFO with simultaneous pop and a new read.
      apply_stimulus(1'b1, 1'b0, 15'd1, '0, 1'b0);
      apply_stimulus(1'b1, 1'b0, 15'd2, '0, 1'b0);
      apply_stimulus(1'b1, 1'b0, 15'd3, '0, 1'b1);
      check_output("full_pp_rdy", {31'b0, req_rdy}, 1);
      check_output("full_pp_d1", rsp_rdata, 32'd3);
      apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1);
      check_output("full_pp_d2", rsp_rdata, 32'd6);
      apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1);
      check_output("full_pp_vld3", {31'b0, rsp_vld}, 1);
      check_output("full_pp_d3", rsp_rdata, 32'd9);
      drain();

      // Asynchronous reset with one read buffered and one in flight.
      apply_stimulus(1'b1, 1'b0, 15'd4, '0, 1'b0);
      apply_stimulus(1'b1, 1'b0, 15'd5, '0, 1'b0);
      apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0);
      check_output("pre_rst_vld", {31'b0, rsp_vld}, 1);
      rst_n = 1'b0;
      #1;
      check_output("async_rst_vld", {31'b0, rsp_vld}, 0);
      check_output("async_rst_rdata", rsp_rdata, '0);
      apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1);
      apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1);
         check_output("no_stale_rsp", {31'b0, rsp_vld}, 0);
      end
      apply_stimulus(1'b1, 1'b0, 15'd7, '0, 1'b1);
      apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1);
      apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1);
      check_output("post_rst_vld", {31'b0, rsp_vld}, 1);
      check_output("post_rst_data", rsp_rdata, 32'd21);
      drain();

      // Random traffic over a small address window to force read/write collisions.
      for (int i = 0; i < 600; i++) begin
         apply_stimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                        AW'($urandom_range(0, 15)), DW'($urandom), 1'($urandom_range(0, 2) != 0));
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
